fp_sub_seq_sp: RTL and testbench

FP_SUB_SEQ_SP -- requirements
Module: fp_sub_seq_sp

---
 rtl/fp_pkg.sv | 31 +++
 rtl/fp_sp_aligner.sv | 47 ++++
 rtl/fp_sub_seq_sp.sv | 156 +++++++++++++++
 tb/tb_fp_sub_seq_sp.sv | 138 +++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the sequential single-precision subtractor:
// field widths, limits, FSM state encoding and operand unpacking.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int SIG_W  = MANT_W + 1;

  localparam logic [EXP_W-1:0] EXP_MAX     = 8'hFF;
  localparam logic [EXP_W-1:0] ALIGN_LIMIT = 8'd24;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] frac;
  } fp_t;

  // Zero exponent means the operand is zero: no hidden bit, fraction dropped.
  function automatic logic [SIG_W-1:0] significand(input fp_t x);
    return (x.exp == '0) ? '0 : {1'b1, x.frac};
  endfunction

endpackage

// File: rtl/fp_sp_aligner.sv
// Combinational operand alignment: picks the operand with the larger exponent
// and right-shifts the other significand by the exponent difference (truncating).
module fp_sp_aligner
  import fp_pkg::*;
(
  input  fp_t              a,
  input  fp_t              b,
  output logic             big_sign,
  output logic [EXP_W-1:0] big_exp,
  output logic [SIG_W-1:0] big_sig,
  output logic             small_sign,
  output logic [SIG_W-1:0] small_sig
);

  logic             a_big;
  logic [EXP_W-1:0] diff;
  logic [SIG_W-1:0] small_raw;

  // NOTE: every output of a combinational block gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    a_big      = (a.exp >= b.exp);
    diff       = '0;
    big_sign   = 1'b0;
    big_exp    = '0;
    big_sig    = '0;
    small_sign = 1'b0;
    small_raw  = '0;
    if (a_big) begin
      diff       = a.exp - b.exp;
      big_sign   = a.sign;
      big_exp    = a.exp;
      big_sig    = significand(a);
      small_sign = b.sign;
      small_raw  = significand(b);
    end else begin
      diff       = b.exp - a.exp;
      big_sign   = b.sign;
      big_exp    = b.exp;
      big_sig    = significand(b);
      small_sign = a.sign;
      small_raw  = significand(a);
    end
    small_sig = (diff >= ALIGN_LIMIT) ? '0 : (small_raw >> diff);
  end

endmodule

// File: rtl/fp_sub_seq_sp.sv
// Multi-cycle IEEE-754 single-precision subtractor (A - B), truncating,
// with a valid/ready handshake on both operand and result sides.
module fp_sub_seq_sp
  import fp_pkg::*;
(
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_Valid,
  output logic        o_Ready,
  input  logic [31:0] i_A,
  input  logic [31:0] i_B,
  output logic        o_Valid,
  input  logic        i_Ready,
  output logic [31:0] o_S
);

  state_t state, state_next;

  fp_t              op_a, op_b;
  logic             al_big_sign, al_small_sign;
  logic [EXP_W-1:0] al_big_exp;
  logic [SIG_W-1:0] al_big_sig, al_small_sig;
  logic             norm_sign;
  logic [EXP_W-1:0] norm_exp;
  logic [SIG_W:0]   norm_sig;
  logic [31:0]      s_reg;

  logic             c_big_sign, c_small_sign;
  logic [EXP_W-1:0] c_big_exp;
  logic [SIG_W-1:0] c_big_sig, c_small_sig;

  logic             add_sign;
  logic [SIG_W:0]   add_sig;
  logic             add_zero;
  logic             norm_done;
  logic [31:0]      norm_result;

  fp_sp_aligner u_aligner (
    .a          (op_a),
    .b          (op_b),
    .big_sign   (c_big_sign),
    .big_exp    (c_big_exp),
    .big_sig    (c_big_sig),
    .small_sign (c_small_sign),
    .small_sig  (c_small_sig)
  );

  // Signed-magnitude add on the registered, aligned significands.
  always_comb begin
    add_sign = 1'b0;
    add_sig  = '0;
    if (al_big_sign == al_small_sign) begin
      add_sig  = {1'b0, al_big_sig} + {1'b0, al_small_sig};
      add_sign = al_big_sign;
    end else if (al_big_sig >= al_small_sig) begin
      add_sig  = {1'b0, al_big_sig} - {1'b0, al_small_sig};
      add_sign = al_big_sign;
    end else begin
      add_sig  = {1'b0, al_small_sig} - {1'b0, al_big_sig};
      add_sign = al_small_sign;
    end
    add_zero = (add_sig == '0);
  end

  // One normalization step; the left-shift case is handled in the register block.
  always_comb begin
    norm_done   = 1'b0;
    norm_result = '0;
    if (norm_sig[SIG_W]) begin
      norm_done = 1'b1;
      if (norm_exp >= EXP_MAX - 8'd1)
        norm_result = {norm_sign, EXP_MAX, {MANT_W{1'b0}}};
      else
        norm_result = {norm_sign, norm_exp + 8'd1, norm_sig[MANT_W:1]};
    end else if (norm_sig[MANT_W]) begin
      norm_done   = 1'b1;
      norm_result = {norm_sign, norm_exp, norm_sig[MANT_W-1:0]};
    end else if (norm_exp <= 8'd1) begin
      norm_done   = 1'b1;
      norm_result = '0;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (i_Valid) state_next = ALIGN;
      ALIGN:   state_next = ADD;
      ADD:     state_next = add_zero ? DONE : NORM;
      NORM:    if (norm_done) state_next = DONE;
      DONE:    if (i_Ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the whole datapath is reset so an aborted
  // operation leaves nothing behind.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      op_a          <= '0;
      op_b          <= '0;
      al_big_sign   <= 1'b0;
      al_big_exp    <= '0;
      al_big_sig    <= '0;
      al_small_sign <= 1'b0;
      al_small_sig  <= '0;
      norm_sign     <= 1'b0;
      norm_exp      <= '0;
      norm_sig      <= '0;
      s_reg         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_Valid) begin
            op_a <= i_A;
            op_b <= {~i_B[31], i_B[30:0]};
          end
        end
        ALIGN: begin
          al_big_sign   <= c_big_sign;
          al_big_exp    <= c_big_exp;
          al_big_sig    <= c_big_sig;
          al_small_sign <= c_small_sign;
          al_small_sig  <= c_small_sig;
        end
        ADD: begin
          norm_sign <= add_sign;
          norm_exp  <= al_big_exp;
          norm_sig  <= add_sig;
          if (add_zero) s_reg <= '0;
        end
        NORM: begin
          if (norm_done) begin
            s_reg <= norm_result;
          end else begin
            norm_sig <= norm_sig << 1;
            norm_exp <= norm_exp - 8'd1;
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

  assign o_Ready = (state == IDLE);
  assign o_Valid = (state == DONE);
  assign o_S     = s_reg;

endmodule

// File: tb/tb_fp_sub_seq_sp.sv
// Directed self-checking bench for fp_sub_seq_sp: results, latency,
// backpressure, special paths and asynchronous reset mid-operation.
module tb_fp_sub_seq_sp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_Valid;
  logic        o_Ready;
  logic [31:0] i_A, i_B;
  logic        o_Valid;
  logic        i_Ready;
  logic [31:0] o_S;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_sub_seq_sp dut (
    .i_Clock   (clk),
    .i_Reset_n (rst_n),
    .i_Valid   (i_Valid),
    .o_Ready   (o_Ready),
    .i_A       (i_A),
    .i_B       (i_B),
    .o_Valid   (o_Valid),
    .i_Ready   (i_Ready),
    .o_S       (o_S)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one operand pair, measure edges until o_Valid, check result, drain.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] s_exp, input int lat_exp);
    int cyc;
    cyc = 0;
    while (!o_Ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, " ready_before"}, {31'd0, o_Ready}, 32'd1);
    i_A = a; i_B = b; i_Valid = 1'b1;
    @(posedge clk); #1;
    i_Valid = 1'b0; i_A = 32'hDEADBEEF; i_B = 32'h12345678;
    cyc = 0;
    while (!o_Valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, " latency"}, cyc, lat_exp);
    check({tag, " result"}, o_S, s_exp);
    check({tag, " ready_busy"}, {31'd0, o_Ready}, 32'd0);
    i_Ready = 1'b1;
    @(posedge clk); #1;
    i_Ready = 1'b0;
    check({tag, " valid_drop"}, {31'd0, o_Valid}, 32'd0);
    check({tag, " ready_back"}, {31'd0, o_Ready}, 32'd1);
  endtask

  initial begin
    int cyc;
    int seen_valid;
    rst_n = 1'b0; i_Valid = 1'b0; i_Ready = 1'b0; i_A = '0; i_B = '0;
    #1;
    check("reset valid", {31'd0, o_Valid}, 32'd0);
    check("reset ready", {31'd0, o_Ready}, 32'd1);
    check("reset s", o_S, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op("basic 3-1",       32'h40400000, 32'h3F800000, 32'h40000000, 3);
    run_op("zero 1-1",        32'h3F800000, 32'h3F800000, 32'h00000000, 2);
    run_op("carry 1-(-1)",    32'h3F800000, 32'hBF800000, 32'h40000000, 3);
    run_op("deep norm",       32'h3F800000, 32'h3F7FFFFF, 32'h34000000, 26);
    run_op("1-(-0.5)",        32'h3F800000, 32'hBF000000, 32'h3FC00000, 3);
    run_op("2-3 neg",         32'h40000000, 32'h40400000, 32'hBF800000, 4);
    run_op("1-0",             32'h3F800000, 32'h00000000, 32'h3F800000, 3);
    run_op("0-1",             32'h00000000, 32'h3F800000, 32'hBF800000, 3);
    run_op("align limit 24",  32'h4B800000, 32'h3F800000, 32'h4B800000, 3);
    run_op("overflow",        32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 3);
    run_op("underflow",       32'h00800000, 32'h00C00000, 32'h00000000, 3);

    // Backpressure: hold DONE with new operands offered, then release.
    i_A = 32'h40400000; i_B = 32'h3F800000; i_Valid = 1'b1;
    @(posedge clk); #1;
    i_Valid = 1'b0;
    cyc = 0;
    while (!o_Valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check("bp latency", cyc, 3);
    i_A = 32'h3F800000; i_B = 32'hBF800000; i_Valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp hold s", o_S, 32'h40000000);
      check("bp hold valid", {31'd0, o_Valid}, 32'd1);
      check("bp hold ready", {31'd0, o_Ready}, 32'd0);
    end
    i_Ready = 1'b1;
    @(posedge clk); #1;
    i_Ready = 1'b0;
    check("bp release valid", {31'd0, o_Valid}, 32'd0);
    check("bp release ready", {31'd0, o_Ready}, 32'd1);
    i_Valid = 1'b0;
    @(posedge clk); #1;
    check("bp no accept on return", {31'd0, o_Ready}, 32'd1);

    // Asynchronous reset during deep normalization.
    i_A = 32'h3F800000; i_B = 32'h3F7FFFFF; i_Valid = 1'b1;
    @(posedge clk); #1;
    i_Valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst valid", {31'd0, o_Valid}, 32'd0);
    check("midrst ready", {31'd0, o_Ready}, 32'd1);
    check("midrst s", o_S, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (o_Valid) seen_valid++;
    end
    check("midrst no stale result", seen_valid, 0);
    check("midrst idle after", {31'd0, o_Ready}, 32'd1);
    run_op("post reset basic", 32'h40400000, 32'h3F800000, 32'h40000000, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
